// File: rtl/cache_mem_bridge_pkg.sv
// Shared constants and state encoding for the cache/memory bridge.
package cache_mem_bridge_pkg;

  localparam int unsigned DEF_BW_WORD_ADDR = 26;
  localparam int unsigned DEF_BW_BLOCK     = 2;
  localparam int unsigned DEF_FIFO_DEPTH   = 8;

  // External interface direction values on ext_rw_o.
  localparam logic EXT_READ  = 1'b0;
  localparam logic EXT_WRITE = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_WR_ISSUE = 3'd1,
    ST_WR_WAIT  = 3'd2,
    ST_RD_ISSUE = 3'd3,
    ST_RD_WAIT  = 3'd4
  } bridge_state_e;

endpackage

// File: rtl/cache_word_fifo.sv
// 32-bit synchronous FIFO with first-word fall-through head.
module cache_word_fifo #(
  parameter int unsigned DEPTH = 8
) (
  input  logic        clock,
  input  logic        resetn,
  input  logic        push,
  input  logic [31:0] push_data,
  input  logic        pop,
  output logic [31:0] pop_data,
  output logic        full,
  output logic        empty
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [31:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic          do_push;
  logic          do_pop;

  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign do_push = push && (!full || do_pop);
  // Head reads as zero when empty so stale storage never leaks out.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/cache_mem_bridge.sv
// Sequences word/block commands from the cache controller into single-word
// external memory transactions, through a write-out and a read-in FIFO.
module cache_mem_bridge
  import cache_mem_bridge_pkg::*;
#(
  parameter int unsigned BW_WORD_ADDR = DEF_BW_WORD_ADDR,
  parameter int unsigned BW_BLOCK     = DEF_BW_BLOCK,
  parameter int unsigned FIFO_DEPTH   = DEF_FIFO_DEPTH
) (
  input  logic                    clock_i,
  input  logic                    resetn_i,
  input  logic                    buffer_write_ack_i,
  input  logic [31:0]             buffer_data_i,
  output logic                    buffer_write_ready_o,
  input  logic                    buffer_read_ack_i,
  output logic [31:0]             buffer_data_o,
  output logic                    buffer_read_ready_o,
  input  logic                    mem_req_i,
  input  logic                    mem_req_block_i,
  input  logic                    mem_rw_i,
  input  logic [BW_WORD_ADDR-1:0] mem_addr_i,
  output logic                    mem_ready_o,
  output logic                    ext_req_o,
  output logic                    ext_rw_o,
  output logic [BW_WORD_ADDR-1:0] ext_addr_o,
  output logic [31:0]             ext_data_o,
  input  logic [31:0]             ext_data_i,
  input  logic                    ext_ack_i,
  output logic                    cmd_drop_o
);

  localparam int unsigned CW = BW_BLOCK + 1;

  bridge_state_e           state_q, state_d;
  logic [BW_WORD_ADDR-1:0] base_q, base_d;
  logic [CW-1:0]           words_q, words_d;
  logic [CW-1:0]           n_q, n_d;
  logic                    req_q, req_d;
  logic                    rw_q, rw_d;
  logic [BW_WORD_ADDR-1:0] addr_q, addr_d;
  logic [31:0]             data_q, data_d;
  logic                    drop_q;

  logic                    wf_pop, wf_full, wf_empty;
  logic [31:0]             wf_head;
  logic                    rf_push, rf_full, rf_empty;
  logic [BW_WORD_ADDR-1:0] issue_addr;

  cache_word_fifo #(.DEPTH(FIFO_DEPTH)) u_write_fifo (
    .clock     (clock_i),
    .resetn    (resetn_i),
    .push      (buffer_write_ack_i),
    .push_data (buffer_data_i),
    .pop       (wf_pop),
    .pop_data  (wf_head),
    .full      (wf_full),
    .empty     (wf_empty)
  );

  cache_word_fifo #(.DEPTH(FIFO_DEPTH)) u_read_fifo (
    .clock     (clock_i),
    .resetn    (resetn_i),
    .push      (rf_push),
    .push_data (ext_data_i),
    .pop       (buffer_read_ack_i),
    .pop_data  (buffer_data_o),
    .full      (rf_full),
    .empty     (rf_empty)
  );

  assign buffer_write_ready_o = !wf_full;
  assign buffer_read_ready_o  = !rf_empty;
  assign mem_ready_o          = (state_q == ST_IDLE);
  assign ext_req_o            = req_q;
  assign ext_rw_o             = rw_q;
  assign ext_addr_o           = addr_q;
  assign ext_data_o           = data_q;
  assign cmd_drop_o           = drop_q;

  // Word offset only touches the low bits, so a block never carries into the tag.
  assign issue_addr = {base_q[BW_WORD_ADDR-1:BW_BLOCK],
                       base_q[BW_BLOCK-1:0] + n_q[BW_BLOCK-1:0]};

  // Next-state, command latch and external request sequencing.
  always_comb begin
    state_d = state_q;
    base_d  = base_q;
    words_d = words_q;
    n_d     = n_q;
    req_d   = req_q;
    rw_d    = rw_q;
    addr_d  = addr_q;
    data_d  = data_q;
    wf_pop  = 1'b0;
    rf_push = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (mem_req_i) begin
          base_d  = mem_req_block_i ? {mem_addr_i[BW_WORD_ADDR-1:BW_BLOCK], {BW_BLOCK{1'b0}}}
                                    : mem_addr_i;
          words_d = mem_req_block_i ? CW'(2 ** BW_BLOCK) : CW'(1);
          n_d     = '0;
          state_d = mem_rw_i ? ST_WR_ISSUE : ST_RD_ISSUE;
        end
      end
      ST_WR_ISSUE: begin
        if (!wf_empty) begin
          wf_pop  = 1'b1;
          data_d  = wf_head;
          req_d   = 1'b1;
          rw_d    = EXT_WRITE;
          addr_d  = issue_addr;
          state_d = ST_WR_WAIT;
        end
      end
      ST_RD_ISSUE: begin
        if (!rf_full) begin
          req_d   = 1'b1;
          rw_d    = EXT_READ;
          addr_d  = issue_addr;
          state_d = ST_RD_WAIT;
        end
      end
      ST_WR_WAIT, ST_RD_WAIT: begin
        if (ext_ack_i) begin
          req_d   = 1'b0;
          n_d     = n_q + 1'b1;
          rf_push = (state_q == ST_RD_WAIT);
          if (n_d == words_q)             state_d = ST_IDLE;
          else if (state_q == ST_WR_WAIT) state_d = ST_WR_ISSUE;
          else                            state_d = ST_RD_ISSUE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and external-interface registers.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      state_q <= ST_IDLE;
      base_q  <= '0;
      words_q <= '0;
      n_q     <= '0;
      req_q   <= 1'b0;
      rw_q    <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      words_q <= words_d;
      n_q     <= n_d;
      req_q   <= req_d;
      rw_q    <= rw_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  // Sticky flag for commands presented while the bridge is busy.
  always_ff @(posedge clock_i or negedge resetn_i) begin
    if (!resetn_i) begin
      drop_q <= 1'b0;
    end else if (mem_req_i && !mem_ready_o) begin
      drop_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cache_mem_bridge.sv
// Randomized bench for cache_mem_bridge with a transaction-level reference model.
module tb_cache_mem_bridge;
  import cache_mem_bridge_pkg::*;

  localparam int AW    = 26;
  localparam int DEPTH = 8;
  localparam int BLK   = 4;

  logic          clock_i = 1'b0;
  logic          resetn_i;
  logic          buffer_write_ack_i;
  logic [31:0]   buffer_data_i;
  logic          buffer_write_ready_o;
  logic          buffer_read_ack_i;
  logic [31:0]   buffer_data_o;
  logic          buffer_read_ready_o;
  logic          mem_req_i;
  logic          mem_req_block_i;
  logic          mem_rw_i;
  logic [AW-1:0] mem_addr_i;
  logic          mem_ready_o;
  logic          ext_req_o;
  logic          ext_rw_o;
  logic [AW-1:0] ext_addr_o;
  logic [31:0]   ext_data_o;
  logic [31:0]   ext_data_i;
  logic          ext_ack_i;
  logic          cmd_drop_o;

  cache_mem_bridge #(
    .BW_WORD_ADDR (AW),
    .BW_BLOCK     (2),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clock_i              (clock_i),
    .resetn_i             (resetn_i),
    .buffer_write_ack_i   (buffer_write_ack_i),
    .buffer_data_i        (buffer_data_i),
    .buffer_write_ready_o (buffer_write_ready_o),
    .buffer_read_ack_i    (buffer_read_ack_i),
    .buffer_data_o        (buffer_data_o),
    .buffer_read_ready_o  (buffer_read_ready_o),
    .mem_req_i            (mem_req_i),
    .mem_req_block_i      (mem_req_block_i),
    .mem_rw_i             (mem_rw_i),
    .mem_addr_i           (mem_addr_i),
    .mem_ready_o          (mem_ready_o),
    .ext_req_o            (ext_req_o),
    .ext_rw_o             (ext_rw_o),
    .ext_addr_o           (ext_addr_o),
    .ext_data_o           (ext_data_o),
    .ext_data_i           (ext_data_i),
    .ext_ack_i            (ext_ack_i),
    .cmd_drop_o           (cmd_drop_o)
  );

  always #5 clock_i = ~clock_i;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: expected external transactions, write-FIFO contents,
  // read-FIFO contents, and words remaining in the current command.
  typedef struct packed {
    logic          rw;
    logic [AW-1:0] addr;
  } txn_t;

  txn_t        exp_q[$];
  logic [31:0] wdata_q[$];
  logic [31:0] rexp_q[$];
  int          words_left = 0;
  bit          busy       = 0;
  txn_t        cur;
  int          lat        = 0;
  bit          ack_drv    = 0;
  logic [31:0] ack_data;
  bit          wpush_pend = 0;
  logic [31:0] wpush_word;
  bit          rpop_pend  = 0;
  bit          exp_drop   = 0;
  bit          poke_drop  = 0;
  int          cmds_issued = 0;

  task automatic issue_cmd(input bit rw, input bit blk, input logic [AW-1:0] addr);
    txn_t          t;
    logic [AW-1:0] base;
    mem_req_i       = 1'b1;
    mem_rw_i        = rw;
    mem_req_block_i = blk;
    mem_addr_i      = addr;
    t.rw = rw;
    if (blk) begin
      base = addr - (addr % AW'(BLK));
      for (int i = 0; i < BLK; i++) begin
        t.addr = base + AW'(i);
        exp_q.push_back(t);
      end
      words_left = BLK;
    end else begin
      t.addr = addr;
      exp_q.push_back(t);
      words_left = 1;
    end
    cmds_issued++;
  endtask

  // One clock of checking and stimulus against the model.
  task automatic model_cycle(input bit allow_cmd);
    int unsigned wsize_pre;
    bit          popped;
    @(posedge clock_i);
    #1;
    if (ack_drv) begin
      ack_drv = 0;
      busy    = 0;
      words_left--;
      if (!cur.rw) rexp_q.push_back(ack_data);
    end
    wsize_pre = wdata_q.size();
    popped    = 0;
    if (!busy && ext_req_o) begin
      if (exp_q.size() == 0) begin
        check_eq("unexpected_txn", ext_req_o, 0);
      end else begin
        cur  = exp_q.pop_front();
        busy = 1;
        lat  = int'($urandom_range(0, 3));
        check_eq("ext_addr", ext_addr_o, cur.addr);
        check_eq("ext_rw", ext_rw_o, cur.rw);
        if (cur.rw) begin
          check_eq("wr_stall", ext_req_o, wdata_q.size() != 0);
          if (wdata_q.size() != 0) begin
            check_eq("ext_wdata", ext_data_o, wdata_q.pop_front());
            popped = 1;
          end
        end else begin
          check_eq("rd_stall", ext_req_o, rexp_q.size() < DEPTH);
        end
      end
    end
    if (rpop_pend) begin
      rpop_pend = 0;
      void'(rexp_q.pop_front());
    end
    if (wpush_pend) begin
      wpush_pend = 0;
      if (wsize_pre < DEPTH || popped) wdata_q.push_back(wpush_word);
    end
    check_eq("mem_ready", mem_ready_o, words_left == 0);
    check_eq("ext_req", ext_req_o, busy);
    check_eq("wr_ready", buffer_write_ready_o, wdata_q.size() < DEPTH);
    check_eq("rd_ready", buffer_read_ready_o, rexp_q.size() != 0);
    if (rexp_q.size() != 0) check_eq("rd_data", buffer_data_o, rexp_q[0]);
    check_eq("cmd_drop", cmd_drop_o, exp_drop);

    mem_req_i          = 1'b0;
    buffer_write_ack_i = 1'b0;
    buffer_read_ack_i  = 1'b0;
    ext_ack_i          = 1'b0;
    ext_data_i         = $urandom();
    if (poke_drop && words_left > 0) begin
      mem_req_i  = 1'b1;
      mem_rw_i   = 1'b1;
      mem_addr_i = AW'($urandom());
      poke_drop  = 0;
      exp_drop   = 1;
    end else if (allow_cmd && words_left == 0 && $urandom_range(0, 3) == 0) begin
      if (cmds_issued == 0)      issue_cmd(1'b0, 1'b1, AW'(32'h000123));
      else if (cmds_issued == 1) issue_cmd(1'b1, 1'b1, AW'(32'h000040));
      else if (cmds_issued == 2) issue_cmd(1'b0, 1'b1, AW'(32'h000080));
      else issue_cmd(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), AW'($urandom()));
    end
    if ($urandom_range(0, 2) == 0) begin
      wpush_word         = $urandom();
      buffer_data_i      = wpush_word;
      buffer_write_ack_i = 1'b1;
      wpush_pend         = 1;
    end
    if (rexp_q.size() != 0) begin
      if ($urandom_range(0, 1) == 0) begin
        buffer_read_ack_i = 1'b1;
        rpop_pend         = 1;
      end
    end else if ($urandom_range(0, 7) == 0) begin
      buffer_read_ack_i = 1'b1;  // pop while empty, must be ignored
    end
    if (busy) begin
      if (lat == 0) begin
        ack_data   = $urandom();
        ext_data_i = ack_data;
        ext_ack_i  = 1'b1;
        ack_drv    = 1;
      end else begin
        lat--;
      end
    end else if ($urandom_range(0, 15) == 0) begin
      ext_ack_i = 1'b1;  // stray ack outside a wait, must be ignored
    end
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 400 && (words_left != 0 || busy); i++) model_cycle(1'b0);
    check_eq(tag, mem_ready_o, 1);
  endtask

  initial begin
    resetn_i           = 1'b0;
    buffer_write_ack_i = 1'b0;
    buffer_data_i      = '0;
    buffer_read_ack_i  = 1'b0;
    mem_req_i          = 1'b0;
    mem_req_block_i    = 1'b0;
    mem_rw_i           = 1'b0;
    mem_addr_i         = '0;
    ext_data_i         = '0;
    ext_ack_i          = 1'b0;
    repeat (2) @(posedge clock_i);
    #1;
    check_eq("rst_mem_ready", mem_ready_o, 1);
    check_eq("rst_ext_req", ext_req_o, 0);
    check_eq("rst_ext_rw", ext_rw_o, 0);
    check_eq("rst_ext_addr", ext_addr_o, 0);
    check_eq("rst_ext_data", ext_data_o, 0);
    check_eq("rst_cmd_drop", cmd_drop_o, 0);
    check_eq("rst_wr_ready", buffer_write_ready_o, 1);
    check_eq("rst_rd_ready", buffer_read_ready_o, 0);
    check_eq("rst_rd_data", buffer_data_o, 0);
    resetn_i = 1'b1;

    // Randomized traffic; the first three commands follow the fixed table.
    for (int c = 0; c < 3000; c++) model_cycle(1'b1);
    drain("drain_random");

    // A command presented while busy is dropped and flagged.
    model_cycle(1'b0);
    issue_cmd(1'b0, 1'b1, AW'($urandom()));
    poke_drop = 1;
    drain("drain_drop");
    check_eq("drop_sticky", cmd_drop_o, 1);

    // Reset in the middle of a block read, after two of four words.
    model_cycle(1'b0);
    issue_cmd(1'b0, 1'b1, AW'($urandom()));
    for (int i = 0; i < 400 && !(busy && words_left == 2); i++) model_cycle(1'b0);
    check_eq("mid_read_reached", ext_req_o, 1);
    resetn_i           = 1'b0;
    mem_req_i          = 1'b0;
    buffer_write_ack_i = 1'b0;
    buffer_read_ack_i  = 1'b0;
    ext_ack_i          = 1'b1;
    #1;
    check_eq("mid_rst_ext_req", ext_req_o, 0);
    check_eq("mid_rst_mem_ready", mem_ready_o, 1);
    check_eq("mid_rst_rd_ready", buffer_read_ready_o, 0);
    check_eq("mid_rst_rd_data", buffer_data_o, 0);
    check_eq("mid_rst_cmd_drop", cmd_drop_o, 0);
    check_eq("mid_rst_wr_ready", buffer_write_ready_o, 1);
    @(posedge clock_i);
    #1;
    resetn_i = 1'b1;
    @(posedge clock_i);  // late ack lands while idle
    #1;
    ext_ack_i = 1'b0;
    check_eq("late_ack_mem_ready", mem_ready_o, 1);
    check_eq("late_ack_ext_req", ext_req_o, 0);
    check_eq("late_ack_rd_ready", buffer_read_ready_o, 0);
    @(posedge clock_i);
    #1;
    check_eq("late_ack_settled", mem_ready_o, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
